alu_seq_ctrl: RTL and testbench

Multi-cycle sequencer that runs W-bit (4·N_NIB) arithmetic and logic commands through the existing 4-bit `alu` one nibble per clock, from least- to most-significant nibble. The carry chains between nibbles through an internal register. The block maps each command onto the `alu` operation lines (`l`, `Op`, `cin`), pre-inverts operands where the 4-bit op set lacks a direct encoding, and assembles the result and Z/C/S flags. It sits between the instruction-level control and the 4-bit datapath.

---
 rtl/alu_seq_ctrl_pkg.sv | 63 ++++++
 rtl/alu_seq_ctrl_alu.sv | 46 ++++
 rtl/alu_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared encodings for the nibble-serial ALU sequencer.
//   cmd_e      : instruction-level command codes
//   OP_*       : 4-bit alu operation-line encodings (l selects the group)
//   state_e    : sequencer FSM states
//   cmd_ctrl_t : per-command alu control, produced by decode_cmd()
package alu_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_ADD = 3'b000,
        CMD_SUB = 3'b001,
        CMD_INC = 3'b010,
        CMD_NEG = 3'b011,
        CMD_AND = 3'b100,
        CMD_OR  = 3'b101,
        CMD_XOR = 3'b110,
        CMD_NOT = 3'b111
    } cmd_e;

    // l = 0 (arithmetic group)
    localparam logic [1:0] OP_A_CIN   = 2'b00;  // A + cin
    localparam logic [1:0] OP_NA_CIN  = 2'b01;  // -A + cin
    localparam logic [1:0] OP_AB_CIN  = 2'b10;  // A + B + cin
    localparam logic [1:0] OP_A1_CIN  = 2'b11;  // A + 1 + cin
    // l = 1 (logic group)
    localparam logic [1:0] OP_AND     = 2'b00;
    localparam logic [1:0] OP_OR      = 2'b01;
    localparam logic [1:0] OP_XOR     = 2'b10;
    localparam logic [1:0] OP_NOT     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic       l;
        logic [1:0] op;
        logic       inv_a;   // feed ~A nibble to the alu
        logic       inv_b;   // feed ~B nibble to the alu
        logic       arith;   // carry chains between nibbles
        logic       cin0;    // carry-in for nibble 0
    } cmd_ctrl_t;

    // The alu has no subtract or increment-by-one-with-chain, so SUB is
    // A + ~B + 1 and NEG is ~A + 1, with the +1 entering as nibble-0 carry.
    function automatic cmd_ctrl_t decode_cmd(input cmd_e cmd);
        cmd_ctrl_t ctl;
        ctl = '0;
        case (cmd)
            CMD_ADD: begin ctl.op = OP_AB_CIN; ctl.arith = 1'b1; end
            CMD_SUB: begin ctl.op = OP_AB_CIN; ctl.arith = 1'b1; ctl.inv_b = 1'b1; ctl.cin0 = 1'b1; end
            CMD_INC: begin ctl.op = OP_A_CIN;  ctl.arith = 1'b1; ctl.cin0 = 1'b1; end
            CMD_NEG: begin ctl.op = OP_A_CIN;  ctl.arith = 1'b1; ctl.inv_a = 1'b1; ctl.cin0 = 1'b1; end
            CMD_AND: begin ctl.l = 1'b1; ctl.op = OP_AND; end
            CMD_OR:  begin ctl.l = 1'b1; ctl.op = OP_OR;  end
            CMD_XOR: begin ctl.l = 1'b1; ctl.op = OP_XOR; end
            default: begin ctl.l = 1'b1; ctl.op = OP_NOT; end
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// 4-bit datapath alu (module alu).
//   a, b : nibble operands      cin : carry in
//   l    : 0 arithmetic, 1 logic
//   op   : operation within the group
//   r    : result   c : carry out (0 for logic)   z : r == 0   s : r[3]
module alu
    import alu_seq_ctrl_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       l,
    input  logic [1:0] op,
    output logic [3:0] r,
    output logic       c,
    output logic       z,
    output logic       s
);
    logic [4:0] sum;

    always_comb begin
        sum = '0;
        r   = '0;
        c   = 1'b0;
        if (l) begin
            case (op)
                OP_AND:  r = a & b;
                OP_OR:   r = a | b;
                OP_XOR:  r = a ^ b;
                default: r = ~a;
            endcase
        end else begin
            case (op)
                OP_A_CIN:  sum = {1'b0, a} + {4'b0, cin};
                OP_NA_CIN: sum = {1'b0, ~a} + 5'd1 + {4'b0, cin};
                OP_AB_CIN: sum = {1'b0, a} + {1'b0, b} + {4'b0, cin};
                default:   sum = {1'b0, a} + 5'd1 + {4'b0, cin};
            endcase
            r = sum[3:0];
            c = sum[4];
        end
    end

    assign z = (r == 4'h0);
    assign s = r[3];
endmodule

// File: rtl/alu_seq_ctrl.sv
// Nibble-serial sequencer: runs W-bit (W = 4*N_NIB) commands through one
// 4-bit alu, LS nibble first, carry chained through carry_q.
//   clk, reset  : clock, synchronous active-high reset
//   start, cmd  : command request (taken in IDLE/DONE), command code
//   a, b        : operands, captured on start accept
//   busy        : nibbles in flight
//   done        : one-cycle pulse, r/z/c/s valid
//   r, z, c, s  : result and flags, updated only at commit
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int N_NIB = 4
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         cmd,
    input  logic [4*N_NIB-1:0] a,
    input  logic [4*N_NIB-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [4*N_NIB-1:0] r,
    output logic               z,
    output logic               c,
    output logic               s
);
    localparam int W  = 4 * N_NIB;
    localparam int IW = $clog2(N_NIB);

    state_e          state, state_nx;
    logic            accept, commit;
    logic [W-1:0]    a_q, b_q, res_q, res_nx;
    cmd_ctrl_t       ctl_q;
    logic [IW-1:0]   idx;
    logic            carry_q, zacc;
    logic [3:0]      alu_a, alu_b, alu_r;
    logic            alu_c, alu_z, alu_s;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        commit   = 1'b0;
        case (state)
            ST_IDLE: if (start) begin state_nx = ST_RUN; accept = 1'b1; end
            ST_RUN:  if (idx == IW'(N_NIB - 1)) begin state_nx = ST_DONE; commit = 1'b1; end
            ST_DONE: begin
                accept   = start;
                state_nx = start ? ST_RUN : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // ---------------- nibble datapath ----------------
    assign alu_a = a_q[idx*4 +: 4] ^ {4{ctl_q.inv_a}};
    assign alu_b = b_q[idx*4 +: 4] ^ {4{ctl_q.inv_b}};

    alu u_alu (
        .a   (alu_a),
        .b   (alu_b),
        .cin (carry_q),
        .l   (ctl_q.l),
        .op  (ctl_q.op),
        .r   (alu_r),
        .c   (alu_c),
        .z   (alu_z),
        .s   (alu_s)
    );

    // Working result with the current nibble merged, so the commit edge
    // sees the full word including the MS nibble.
    always_comb begin
        res_nx = res_q;
        res_nx[idx*4 +: 4] = alu_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            ctl_q   <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            zacc    <= 1'b0;
            res_q   <= '0;
            r       <= '0;
            z       <= 1'b0;
            c       <= 1'b0;
            s       <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            ctl_q   <= decode_cmd(cmd_e'(cmd));
            idx     <= '0;
            carry_q <= decode_cmd(cmd_e'(cmd)).cin0;
            zacc    <= 1'b1;
            res_q   <= '0;
        end else if (state == ST_RUN) begin
            res_q <= res_nx;
            zacc  <= zacc & alu_z;
            idx   <= idx + 1'b1;
            if (ctl_q.arith) carry_q <= alu_c;
            if (commit) begin
                r <= res_nx;
                z <= zacc & alu_z;
                c <= ctl_q.arith & alu_c;
                s <= alu_s;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;
    localparam int N_NIB = 4;
    localparam int W     = 4 * N_NIB;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   cmd;
    logic [W-1:0] a, b, r;
    logic         busy, done, z, c, s;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_ctrl #(.N_NIB(N_NIB)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .a(a), .b(b),
        .busy(busy), .done(done), .r(r), .z(z), .c(c), .s(s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Call #1 after an edge; returns #1 after the accept edge E0.
    task automatic issue(input logic [2:0] cm, input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1; cmd = cm; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;   // operands must already be captured
    endtask

    // From #1 after E0: busy through E3, commit at E4. Returns in the done cycle.
    task automatic finish(input string tag, input logic [W-1:0] er,
                          input logic ez, input logic ec, input logic es);
        for (int k = 1; k < N_NIB; k++) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " no early done"}, 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        chk({tag, " busy last"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy low"}, 32'(busy), 32'd0);
        chk({tag, " r"}, 32'(r), 32'(er));
        chk({tag, " z"}, 32'(z), 32'(ez));
        chk({tag, " c"}, 32'(c), 32'(ec));
        chk({tag, " s"}, 32'(s), 32'(es));
    endtask

    task automatic after_done(input string tag, input logic [W-1:0] er);
        @(posedge clk); #1;
        chk({tag, " done pulse width"}, 32'(done), 32'd0);
        chk({tag, " r held"}, 32'(r), 32'(er));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cmd = 3'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst r", 32'(r), 32'd0);
        chk("rst zcs", {29'd0, z, c, s}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        issue(3'b000, 16'h1234, 16'h0FCD); finish("add1", 16'h2201, 0, 0, 0); after_done("add1", 16'h2201);
        issue(3'b000, 16'hFFFF, 16'h0001); finish("add2", 16'h0000, 1, 1, 0); after_done("add2", 16'h0000);
        issue(3'b001, 16'h0005, 16'h0007); finish("sub1", 16'hFFFE, 0, 0, 1); after_done("sub1", 16'hFFFE);
        issue(3'b001, 16'h0007, 16'h0005); finish("sub2", 16'h0002, 0, 1, 0); after_done("sub2", 16'h0002);
        issue(3'b011, 16'h0001, 16'h1234); finish("neg1", 16'hFFFF, 0, 0, 1); after_done("neg1", 16'hFFFF);
        issue(3'b011, 16'h0000, 16'h1234); finish("neg0", 16'h0000, 1, 1, 0); after_done("neg0", 16'h0000);
        issue(3'b010, 16'h00FF, 16'h5555); finish("inc",  16'h0100, 0, 0, 0); after_done("inc",  16'h0100);
        issue(3'b110, 16'hA5A5, 16'hFFFF); finish("xor",  16'h5A5A, 0, 0, 0); after_done("xor",  16'h5A5A);
        issue(3'b100, 16'hF0F0, 16'h0F0F); finish("and",  16'h0000, 1, 0, 0);
        // back-to-back: start in the done cycle, no bubble
        issue(3'b111, 16'h0000, 16'h1111); finish("not b2b", 16'hFFFF, 0, 0, 1); after_done("not", 16'hFFFF);

        // start during RUN is ignored
        issue(3'b000, 16'h0001, 16'h0001);
        start = 1'b1; cmd = 3'b111; a = 16'h0F0F;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("ign busy2", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("ign busy3", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("ign done", 32'(done), 32'd1);
        chk("ign r", 32'(r), 32'h0002);
        begin
            int extra;
            extra = 0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                if (done || busy) extra++;
            end
            chk("ign single done", 32'(extra), 32'd0);
        end

        // reset mid-RUN discards the command
        issue(3'b000, 16'h1111, 16'h2222);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst done", 32'(done), 32'd0);
        chk("mid rst r", 32'(r), 32'd0);
        chk("mid rst zcs", {29'd0, z, c, s}, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                if (done || busy) seen++;
            end
            chk("mid rst no done", 32'(seen), 32'd0);
        end
        issue(3'b001, 16'h1000, 16'h0001); finish("post rst sub", 16'h0FFF, 0, 1, 0);
        after_done("post rst sub", 16'h0FFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
